// File: rtl/wind_input_conditioner.sv
// Wind switch synchroniser/debouncer with step prescaler for the landing-light sequencer.
// Optional: define WIND_STEP_RESYNC_EN to restart the step phase on a new direction.
module wind_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  output logic [1:0] wind,
  output logic       wind_valid,
  output logic       fault,
  output logic       step
);

  localparam int DW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0]                  sync;
  logic [1:0]                  cand;
  logic [CW-1:0]               cnt;
  logic [DW-1:0]               div;
  logic                        accept;
  logic                        legal;
  logic                        term;
  logic                        resync;

  assign sync  = sync_q[SYNC_STAGES-1];
  assign legal = (cand != 2'b11);
  assign term  = (div == DW'(TICK_DIV - 1));

  // Fires only on the edge where cnt reaches the limit, so no re-accept.
  assign accept = (sync == cand)
               && (cnt == CW'(DEBOUNCE_CYCLES - 1));

`ifdef WIND_STEP_RESYNC_EN
  assign resync = accept && legal
               && (!wind_valid || (cand != wind));
`else
  assign resync = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand <= 2'b00;
      cnt  <= '0;
    end else if (sync != cand) begin
      cand <= sync;
      cnt  <= '0;
    end else if (cnt < CW'(DEBOUNCE_CYCLES)) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wind       <= 2'b00;
      wind_valid <= 1'b0;
      fault      <= 1'b0;
    end else if (accept) begin
      if (legal) begin
        wind       <= cand;
        wind_valid <= 1'b1;
        fault      <= 1'b0;
      end else begin
        fault <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (resync || term) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  // Gated by the registered flags, so an acceptance edge cannot glitch it.
  assign step = term && wind_valid && !fault;

endmodule

// File: tb/tb_wind_input_conditioner.sv
// Randomised bench for wind_input_conditioner against a sample-history model.
// Build with WIND_STEP_RESYNC_EN defined to check the resync variant.
module tb_wind_input_conditioner;

  localparam int S = 2;
  localparam int D = 4;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] sw_raw = 2'b00;
  logic [1:0] wind;
  logic       wind_valid;
  logic       fault;
  logic       step;

  int tests = 0;
  int fails = 0;

  int e;
  int origin;
  int m_wind;
  int m_valid;
  int m_fault;
  int sw_hist[$];
  int sync_hist[$];
  bit resync_en;
  int prev_step;

  wind_input_conditioner #(
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D),
    .TICK_DIV(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_raw(sw_raw),
    .wind(wind),
    .wind_valid(wind_valid),
    .fault(fault),
    .step(step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e = 0;
    origin = 0;
    m_wind = 0;
    m_valid = 0;
    m_fault = 0;
    prev_step = 0;
    sw_hist.delete();
    sync_hist.delete();
    sync_hist.push_back(0);
  endtask

  function automatic int exp_step();
    int d;
    d = (e - origin) % T;
    return (d == T - 1 && m_valid == 1 && m_fault == 0) ? 1 : 0;
  endfunction

  // One clock edge: sync sees the switch value sampled S edges earlier;
  // a code is accepted when it has been seen D+1 times in a row.
  task automatic model_edge();
    int s;
    int n;
    bit acc;
    s = (e >= S) ? sw_hist[e - S] : 0;
    sw_hist.push_back(int'(sw_raw));
    sync_hist.push_back(s);
    n = sync_hist.size();
    acc = (n >= D + 1);
    for (int i = n - D - 1; acc && i < n; i++)
      if (sync_hist[i] != s) acc = 1'b0;
    if (acc && n > D + 1 && sync_hist[n - D - 2] == s) acc = 1'b0;
    if (acc) begin
      if (s != 3) begin
        if (resync_en && (m_valid == 0 || s != m_wind)) origin = e + 1;
        m_wind = s;
        m_valid = 1;
        m_fault = 0;
      end else begin
        m_fault = 1;
      end
    end
    e++;
  endtask

  task automatic check_outputs(input string tag);
    int es;
    es = exp_step();
    chk({tag, ".wind"}, 4'(wind), 4'(m_wind));
    chk({tag, ".valid"}, 4'(wind_valid), 4'(m_valid));
    chk({tag, ".fault"}, 4'(fault), 4'(m_fault));
    chk({tag, ".step"}, 4'(step), 4'(es));
    if (prev_step == 1) chk({tag, ".step_double"}, 4'(step), 4'd0);
    prev_step = int'(step);
  endtask

  task automatic cyc(input logic [1:0] v, input string tag);
    sw_raw = v;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".wind"}, 4'(wind), 4'd0);
    chk({tag, ".valid"}, 4'(wind_valid), 4'd0);
    chk({tag, ".fault"}, 4'(fault), 4'd0);
    chk({tag, ".step"}, 4'(step), 4'd0);
  endtask

  task automatic rand_segments(input int total, input string tag);
    int done;
    logic [1:0] code;
    int len;
    done = 0;
    while (done < total) begin
      code = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) cyc(code, tag);
      done += len;
    end
  endtask

  initial begin
`ifdef WIND_STEP_RESYNC_EN
    resync_en = 1'b1;
`else
    resync_en = 1'b0;
`endif
    model_reset();

    reset = 1'b0;
    sw_raw = 2'b01;
    #1;
    check_zero("reset_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_zero("reset_hold");
    end
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 30; i++) cyc(2'b01, "acquire");

    for (int i = 0; i < 3; i++) cyc(2'b10, "glitch");
    for (int i = 0; i < 20; i++) cyc(2'b01, "glitch_after");

    for (int i = 0; i < 10; i++) cyc(2'b11, "illegal");
    for (int i = 0; i < 24; i++) cyc(2'b00, "recover");

    for (int i = 0; i < 20; i++) cyc(2'b01, "pre_change");
    while (((e + 6 - origin) % T) != 5) cyc(2'b01, "align");
    for (int i = 0; i < 20; i++) cyc(2'b10, "dir_change");

    for (int i = 0; i < 50; i++)
      cyc((i % 2 == 0) ? 2'b01 : 2'b10, "toggle");

    for (int i = 0; i < 20; i++) cyc(2'b01, "pre_reset");
    while (((e - origin) % T) != 5) cyc(2'b01, "pre_reset_align");
    for (int i = 0; i < 3; i++) cyc(2'b10, "mid_debounce");
    #2;
    reset = 1'b0;
    #1;
    check_zero("reset_mid");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("reset_mid_hold");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) cyc(2'b10, "reacquire");

    rand_segments(600, "random");

    #2;
    reset = 1'b0;
    #1;
    check_zero("reset_final");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) cyc(2'b00, "calm_from_reset");
    rand_segments(300, "random2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
